// File: rtl/nw_vc_credit_tracker_if.sv
// Flit/credit/flow-control bundle between a router output port (master side,
// which sends flits and receives downstream credits) and its per-VC tracker (slave).
interface nw_vc_credit_tracker_if #(
  parameter int num_vcs      = 4,
  parameter int counter_bits = 3
);
  logic                            flit_valid;
  logic [num_vcs-1:0]              flit_vc;
  logic [num_vcs-1:0]              credit_valid;
  logic [num_vcs-1:0]              nearly_full;
  logic                            clear_errors;
  logic [num_vcs-1:0]              vc_status;
  logic [num_vcs-1:0]              vc_empty;
  logic [num_vcs-1:0]              vc_low;
  logic [num_vcs*counter_bits-1:0] vc_credits;
  logic                            err_underflow;
  logic                            err_overflow;
  logic                            err_onehot;

  modport master (
    output flit_valid, flit_vc, credit_valid, nearly_full, clear_errors,
    input  vc_status, vc_empty, vc_low, vc_credits,
           err_underflow, err_overflow, err_onehot
  );

  modport slave (
    input  flit_valid, flit_vc, credit_valid, nearly_full, clear_errors,
    output vc_status, vc_empty, vc_low, vc_credits,
           err_underflow, err_overflow, err_onehot
  );
endinterface

// File: rtl/nw_vc_credit_tracker.sv
// Per-VC output flow-control tracker: credit counters (fc_mode=0) or stop/go
// FSMs (fc_mode=1), optional input register stage, low-watermark decode and
// sticky protocol-error flags.
module nw_vc_credit_tracker #(
  parameter int num_vcs       = 4,
  parameter int init_credits  = 4,
  parameter int low_watermark = 1,
  parameter bit fc_mode       = 1'b0,
  parameter bit reg_inputs    = 1'b1,
  parameter int counter_bits  = $clog2(init_credits + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nw_vc_credit_tracker_if.slave  bus
);

  localparam logic [counter_bits-1:0] CNT_INIT = counter_bits'(init_credits);
  localparam logic [counter_bits-1:0] CNT_LOW  = counter_bits'(low_watermark);

  // Raw events decoded from the current inputs.
  logic               flit_onehot;
  logic [num_vcs-1:0] dec_raw, inc_raw;
  logic               bad_raw;

  // Events as seen by the counters/FSMs (raw or one cycle late).
  logic [num_vcs-1:0] dec_ev, inc_ev;
  logic               bad_ev;

  // Per-VC error hits from the active flow-control engine.
  logic [num_vcs-1:0] ovf_hit, unf_hit;

  logic [num_vcs-1:0]              status_w, empty_w, low_w;
  logic [num_vcs*counter_bits-1:0] credits_w;

  logic unf_q, unf_d, ovf_q, ovf_d, oh_q, oh_d;

  // Decode flit/credit inputs; a non-one-hot flit is flagged and otherwise ignored.
  always_comb begin
    flit_onehot = $onehot(bus.flit_vc);
    dec_raw     = bus.flit_vc & {num_vcs{bus.flit_valid & flit_onehot}};
    inc_raw     = bus.credit_valid;
    bad_raw     = bus.flit_valid & ~flit_onehot;
  end

  generate
    if (reg_inputs) begin : g_in_reg
      logic [num_vcs-1:0] dec_q, inc_q;
      logic               bad_q;

      // Input pipeline stage; reset discards any pending event.
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dec_q <= '0;
          inc_q <= '0;
          bad_q <= 1'b0;
        end else begin
          dec_q <= dec_raw;
          inc_q <= inc_raw;
          bad_q <= bad_raw;
        end
      end

      assign dec_ev = dec_q;
      assign inc_ev = inc_q;
      assign bad_ev = bad_q;
    end else begin : g_in_comb
      assign dec_ev = dec_raw;
      assign inc_ev = inc_raw;
      assign bad_ev = bad_raw;
    end

    if (!fc_mode) begin : g_credit
      logic [counter_bits-1:0] cnt_q [num_vcs];
      logic [counter_bits-1:0] cnt_d [num_vcs];

      // Saturating credit counters: simultaneous inc/dec cancel, never wrap.
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned (which would infer a latch).
      always_comb begin
        ovf_hit = '0;
        unf_hit = '0;
        for (int i = 0; i < num_vcs; i++) begin
          cnt_d[i] = cnt_q[i];
          if (inc_ev[i] && !dec_ev[i]) begin
            if (cnt_q[i] == CNT_INIT) ovf_hit[i] = 1'b1;
            else                      cnt_d[i]   = cnt_q[i] + 1'b1;
          end else if (dec_ev[i] && !inc_ev[i]) begin
            if (cnt_q[i] == '0) unf_hit[i] = 1'b1;
            else                cnt_d[i]   = cnt_q[i] - 1'b1;
          end
        end
      end

      // Credit counter registers.
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset element by element to the downstream buffer depth.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < num_vcs; i++) cnt_q[i] <= CNT_INIT;
        end else begin
          for (int i = 0; i < num_vcs; i++) cnt_q[i] <= cnt_d[i];
        end
      end

      // Status decodes of the registered counters.
      always_comb begin
        credits_w = '0;
        for (int i = 0; i < num_vcs; i++) begin
          status_w[i] = (cnt_q[i] == '0);
          empty_w[i]  = (cnt_q[i] == CNT_INIT);
          low_w[i]    = (cnt_q[i] <= CNT_LOW);
          credits_w[i*counter_bits +: counter_bits] = cnt_q[i];
        end
      end
    end else begin : g_stop_go
      typedef enum logic {SG_GO = 1'b0, SG_STOP = 1'b1} sg_state_e;
      sg_state_e state_q [num_vcs];
      sg_state_e state_d [num_vcs];

      // Stop/go next state: stop on a flit into a nearly-full VC, go when it drains.
      always_comb begin
        for (int i = 0; i < num_vcs; i++) begin
          state_d[i] = state_q[i];
          case (state_q[i])
            SG_GO:   if (bus.nearly_full[i] && dec_ev[i]) state_d[i] = SG_STOP;
            SG_STOP: if (!bus.nearly_full[i])             state_d[i] = SG_GO;
            default: state_d[i] = SG_GO;
          endcase
        end
      end

      // Stop/go state registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < num_vcs; i++) state_q[i] <= SG_GO;
        end else begin
          for (int i = 0; i < num_vcs; i++) state_q[i] <= state_d[i];
        end
      end

      // Status decodes; credit count is fixed and credit errors cannot occur.
      always_comb begin
        ovf_hit   = '0;
        unf_hit   = '0;
        credits_w = {num_vcs{CNT_INIT}};
        for (int i = 0; i < num_vcs; i++) begin
          status_w[i] = (state_q[i] == SG_STOP);
          low_w[i]    = (state_q[i] == SG_STOP);
          empty_w[i]  = (state_q[i] == SG_GO);
        end
      end
    end
  endgenerate

  // Sticky error next state: a new error event outranks clear_errors.
  always_comb begin
    unf_d = (bus.clear_errors ? 1'b0 : unf_q) | (|unf_hit);
    ovf_d = (bus.clear_errors ? 1'b0 : ovf_q) | (|ovf_hit);
    oh_d  = (bus.clear_errors ? 1'b0 : oh_q)  | bad_ev;
  end

  // Sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unf_q <= 1'b0;
      ovf_q <= 1'b0;
      oh_q  <= 1'b0;
    end else begin
      unf_q <= unf_d;
      ovf_q <= ovf_d;
      oh_q  <= oh_d;
    end
  end

  assign bus.vc_status     = status_w;
  assign bus.vc_empty      = empty_w;
  assign bus.vc_low        = low_w;
  assign bus.vc_credits    = credits_w;
  assign bus.err_underflow = unf_q;
  assign bus.err_overflow  = ovf_q;
  assign bus.err_onehot    = oh_q;

endmodule

// File: tb/tb_nw_vc_credit_tracker.sv
// Directed bench for nw_vc_credit_tracker: a credit-mode instance and a
// stop/go instance, both with registered inputs, sharing clock and reset.
module tb_nw_vc_credit_tracker;
  localparam int NV = 4;
  localparam int CB = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nw_vc_credit_tracker_if #(.num_vcs(NV), .counter_bits(CB)) c_if ();
  nw_vc_credit_tracker_if #(.num_vcs(NV), .counter_bits(CB)) s_if ();

  nw_vc_credit_tracker #(
    .num_vcs(NV), .init_credits(4), .low_watermark(1),
    .fc_mode(1'b0), .reg_inputs(1'b1), .counter_bits(CB)
  ) u_credit (
    .clk(clk), .rst_n(rst_n), .bus(c_if)
  );

  nw_vc_credit_tracker #(
    .num_vcs(NV), .init_credits(4), .low_watermark(1),
    .fc_mode(1'b1), .reg_inputs(1'b1), .counter_bits(CB)
  ) u_stopgo (
    .clk(clk), .rst_n(rst_n), .bus(s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NV*CB-1:0] creds(input int a3, input int a2, input int a1, input int a0);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_if.flit_valid = 1'b0; c_if.flit_vc = '0; c_if.credit_valid = '0;
    c_if.nearly_full = '0; c_if.clear_errors = 1'b0;
    s_if.flit_valid = 1'b0; s_if.flit_vc = '0; s_if.credit_valid = '0;
    s_if.nearly_full = '0; s_if.clear_errors = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    checks++; if (c_if.vc_credits !== creds(4,4,4,4)) begin errors++; $display("FAIL reset_credits got %h want %h", c_if.vc_credits, creds(4,4,4,4)); end
    checks++; if (c_if.vc_empty !== 4'b1111) begin errors++; $display("FAIL reset_empty got %b want 1111", c_if.vc_empty); end
    checks++; if (c_if.vc_status !== 4'b0000 || c_if.vc_low !== 4'b0000) begin errors++; $display("FAIL reset_status_low got %b/%b want 0000/0000", c_if.vc_status, c_if.vc_low); end
    checks++; if ({c_if.err_underflow, c_if.err_overflow, c_if.err_onehot} !== 3'b000) begin errors++; $display("FAIL reset_errs got %b want 000", {c_if.err_underflow, c_if.err_overflow, c_if.err_onehot}); end
    checks++; if (s_if.vc_status !== 4'b0000 || s_if.vc_empty !== 4'b1111) begin errors++; $display("FAIL reset_stopgo got %b/%b want 0000/1111", s_if.vc_status, s_if.vc_empty); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_drain_vc0();
    int exp_cnt [4] = '{4, 3, 2, 1};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      c_if.flit_valid = 1'b1; c_if.flit_vc = 4'b0001;
      cycle();
      checks++; if (c_if.vc_credits !== creds(4,4,4,exp_cnt[k])) begin errors++; $display("FAIL drain_cnt[%0d] got %h want %h", k, c_if.vc_credits, creds(4,4,4,exp_cnt[k])); end
      checks++; if (c_if.vc_low[0] !== (exp_cnt[k] <= 1)) begin errors++; $display("FAIL drain_low[%0d] got %b want %b", k, c_if.vc_low[0], exp_cnt[k] <= 1); end
      checks++; if (c_if.vc_status[0] !== 1'b0) begin errors++; $display("FAIL drain_status_early[%0d] got %b want 0", k, c_if.vc_status[0]); end
    end
    idle();
    cycle();
    checks++; if (c_if.vc_credits !== creds(4,4,4,0)) begin errors++; $display("FAIL drain_zero got %h want %h", c_if.vc_credits, creds(4,4,4,0)); end
    checks++; if (c_if.vc_status !== 4'b0001) begin errors++; $display("FAIL drain_status got %b want 0001", c_if.vc_status); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    c_if.flit_valid = 1'b1; c_if.flit_vc = 4'b0010;
    cycle();
    cycle();
    idle();
    cycle();
    cycle();
    checks++; if (c_if.vc_credits !== creds(4,4,2,4)) begin errors++; $display("FAIL simul_pre got %h want %h", c_if.vc_credits, creds(4,4,2,4)); end
    c_if.flit_valid = 1'b1; c_if.flit_vc = 4'b0010; c_if.credit_valid = 4'b0010;
    cycle();
    idle();
    cycle();
    cycle();
    checks++; if (c_if.vc_credits !== creds(4,4,2,4)) begin errors++; $display("FAIL simul_cnt got %h want %h", c_if.vc_credits, creds(4,4,2,4)); end
    checks++; if ({c_if.err_underflow, c_if.err_overflow, c_if.err_onehot} !== 3'b000) begin errors++; $display("FAIL simul_errs got %b want 000", {c_if.err_underflow, c_if.err_overflow, c_if.err_onehot}); end
  endtask

  task automatic test_multi_credit();
    logic [3:0] vcs [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      c_if.flit_valid = 1'b1; c_if.flit_vc = vcs[k];
      cycle();
    end
    idle();
    cycle();
    checks++; if (c_if.vc_credits !== creds(3,3,3,3)) begin errors++; $display("FAIL multi_spent got %h want %h", c_if.vc_credits, creds(3,3,3,3)); end
    checks++; if (c_if.vc_empty !== 4'b0000 || c_if.vc_low !== 4'b0000) begin errors++; $display("FAIL multi_spent_flags got %b/%b want 0000/0000", c_if.vc_empty, c_if.vc_low); end
    c_if.credit_valid = 4'b1111;
    cycle();
    idle();
    cycle();
    checks++; if (c_if.vc_credits !== creds(4,4,4,4)) begin errors++; $display("FAIL multi_return got %h want %h", c_if.vc_credits, creds(4,4,4,4)); end
    checks++; if (c_if.vc_empty !== 4'b1111 || c_if.err_overflow !== 1'b0) begin errors++; $display("FAIL multi_empty got %b ovf %b want 1111 ovf 0", c_if.vc_empty, c_if.err_overflow); end
  endtask

  task automatic test_errors();
    apply_reset();
    c_if.flit_valid = 1'b1; c_if.flit_vc = 4'b0100;
    repeat (4) cycle();
    idle();
    cycle();
    checks++; if (c_if.vc_credits !== creds(4,0,4,4) || c_if.err_underflow !== 1'b0) begin errors++; $display("FAIL err_pre got %h unf %b want %h unf 0", c_if.vc_credits, c_if.err_underflow, creds(4,0,4,4)); end
    c_if.flit_valid = 1'b1; c_if.flit_vc = 4'b0100;
    cycle();
    idle();
    cycle();
    checks++; if (c_if.err_underflow !== 1'b1 || c_if.vc_credits !== creds(4,0,4,4)) begin errors++; $display("FAIL err_underflow got %b cnt %h want 1 cnt %h", c_if.err_underflow, c_if.vc_credits, creds(4,0,4,4)); end
    c_if.clear_errors = 1'b1;
    cycle();
    c_if.clear_errors = 1'b0;
    checks++; if (c_if.err_underflow !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", c_if.err_underflow); end
    c_if.credit_valid = 4'b1000;
    cycle();
    idle();
    cycle();
    checks++; if (c_if.err_overflow !== 1'b1 || c_if.vc_credits !== creds(4,0,4,4) || c_if.err_underflow !== 1'b0) begin errors++; $display("FAIL err_overflow got ovf %b unf %b cnt %h want 1 0 %h", c_if.err_overflow, c_if.err_underflow, c_if.vc_credits, creds(4,0,4,4)); end
    c_if.clear_errors = 1'b1;
    cycle();
    c_if.clear_errors = 1'b0;
    c_if.credit_valid = 4'b1000;
    cycle();
    c_if.credit_valid = 4'b0000; c_if.clear_errors = 1'b1;
    cycle();
    checks++; if (c_if.err_overflow !== 1'b1) begin errors++; $display("FAIL err_set_beats_clear got %b want 1", c_if.err_overflow); end
    cycle();
    c_if.clear_errors = 1'b0;
    checks++; if (c_if.err_overflow !== 1'b0) begin errors++; $display("FAIL err_clear_after got %b want 0", c_if.err_overflow); end
    c_if.flit_valid = 1'b1; c_if.flit_vc = 4'b0011;
    cycle();
    idle();
    cycle();
    checks++; if (c_if.err_onehot !== 1'b1 || c_if.vc_credits !== creds(4,0,4,4)) begin errors++; $display("FAIL err_onehot_credit got %b cnt %h want 1 cnt %h", c_if.err_onehot, c_if.vc_credits, creds(4,0,4,4)); end
  endtask

  task automatic test_stop_go();
    apply_reset();
    s_if.nearly_full = 4'b0010;
    cycle();
    cycle();
    checks++; if (s_if.vc_status !== 4'b0000) begin errors++; $display("FAIL sg_nf_no_flit got %b want 0000", s_if.vc_status); end
    s_if.nearly_full = 4'b0001; s_if.flit_valid = 1'b1; s_if.flit_vc = 4'b0001;
    cycle();
    s_if.flit_valid = 1'b0; s_if.flit_vc = '0;
    checks++; if (s_if.vc_status !== 4'b0000) begin errors++; $display("FAIL sg_pipe_delay got %b want 0000", s_if.vc_status); end
    cycle();
    checks++; if (s_if.vc_status !== 4'b0001 || s_if.vc_low !== 4'b0001 || s_if.vc_empty !== 4'b1110) begin errors++; $display("FAIL sg_stop got st %b low %b emp %b want 0001 0001 1110", s_if.vc_status, s_if.vc_low, s_if.vc_empty); end
    checks++; if (s_if.vc_credits !== creds(4,4,4,4) || s_if.err_underflow !== 1'b0 || s_if.err_overflow !== 1'b0) begin errors++; $display("FAIL sg_credits got %h unf %b ovf %b want %h 0 0", s_if.vc_credits, s_if.err_underflow, s_if.err_overflow, creds(4,4,4,4)); end
    s_if.nearly_full = 4'b0000;
    cycle();
    checks++; if (s_if.vc_status !== 4'b0000 || s_if.vc_empty !== 4'b1111) begin errors++; $display("FAIL sg_go got st %b emp %b want 0000 1111", s_if.vc_status, s_if.vc_empty); end
    s_if.nearly_full = 4'b0011; s_if.flit_valid = 1'b1; s_if.flit_vc = 4'b0011;
    cycle();
    s_if.flit_valid = 1'b0; s_if.flit_vc = '0;
    cycle();
    checks++; if (s_if.err_onehot !== 1'b1 || s_if.vc_status !== 4'b0000) begin errors++; $display("FAIL sg_onehot got err %b st %b want 1 0000", s_if.err_onehot, s_if.vc_status); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    c_if.flit_valid = 1'b1; c_if.flit_vc = 4'b0001;
    s_if.nearly_full = 4'b0001; s_if.flit_valid = 1'b1; s_if.flit_vc = 4'b0001;
    cycle();
    s_if.flit_valid = 1'b0; s_if.flit_vc = '0;
    cycle();
    c_if.flit_vc = 4'b0000;
    cycle();
    c_if.flit_vc = 4'b0001;
    cycle();
    idle();
    checks++; if (c_if.vc_credits !== creds(4,4,4,2) || c_if.err_onehot !== 1'b1 || s_if.vc_status !== 4'b0001) begin errors++; $display("FAIL mid_pre got %h oh %b sg %b want %h 1 0001", c_if.vc_credits, c_if.err_onehot, s_if.vc_status, creds(4,4,4,2)); end
    rst_n = 1'b0;
    #2;
    checks++; if (c_if.vc_credits !== creds(4,4,4,4) || c_if.vc_empty !== 4'b1111 || c_if.err_onehot !== 1'b0) begin errors++; $display("FAIL mid_async got %h emp %b oh %b want %h 1111 0", c_if.vc_credits, c_if.vc_empty, c_if.err_onehot, creds(4,4,4,4)); end
    checks++; if (s_if.vc_status !== 4'b0000 || s_if.vc_empty !== 4'b1111) begin errors++; $display("FAIL mid_async_sg got %b/%b want 0000/1111", s_if.vc_status, s_if.vc_empty); end
    #2;
    rst_n = 1'b1;
    cycle();
    cycle();
    checks++; if (c_if.vc_credits !== creds(4,4,4,4)) begin errors++; $display("FAIL mid_pending_discarded got %h want %h", c_if.vc_credits, creds(4,4,4,4)); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_drain_vc0();
    test_simultaneous();
    test_multi_credit();
    test_errors();
    test_stop_go();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
